crot_scheduler: RTL and testbench

Sequential front-end for the combinational controlled-rotation datapath in the QFT core. It holds the 2^NQ-amplitude state vector in a register bank. On `start` it walks the bank, presenting each amplitude whose control and target bits are both 1 to the external rotation unit, and writes the rotated result back. All other amplitudes are left untouched, so the rotation is truly controlled.

---
 rtl/crot_pkg.sv | 54 +++++
 rtl/crot_index_gen.sv | 66 ++++++
 rtl/crot_scheduler.sv | 148 ++++++++++++++
 tb/tb_crot_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crot_pkg.sv
// crot_pkg: shared definitions for the controlled-rotation scheduler.
//   - TOTAL_WIDTH: amplitude/angle width (S3.4 signed, 8 bits), mirrors fixed_point_params.vh
//   - crot_state_e: scheduler FSM encoding
//   - AMP_ONE / AMP_ZERO: reset amplitudes for the |0> state
//   - is_qual / insert_ones: qualifying-index helpers (bit test / bit insert)
package crot_pkg;

   localparam int unsigned TOTAL_WIDTH = 8;

   // Helper vectors are sized for the widest legal index so one function serves every NQ.
   localparam int unsigned QIW = 3;
   localparam int unsigned IXW = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StScan = 2'd1,
      StFin  = 2'd2
   } crot_state_e;

   localparam logic [TOTAL_WIDTH-1:0] AMP_ONE  = TOTAL_WIDTH'(16);
   localparam logic [TOTAL_WIDTH-1:0] AMP_ZERO = '0;

   typedef struct packed {
      logic [TOTAL_WIDTH-1:0] r;
      logic [TOTAL_WIDTH-1:0] i;
   } amp_t;

   // True when address idx has both the control and the target bit set.
   function automatic logic is_qual(input logic [IXW-1:0] idx,
                                    input logic [QIW-1:0] ctrl,
                                    input logic [QIW-1:0] tgt);
      return idx[ctrl] & idx[tgt];
   endfunction

   // Spread the counter bits over all positions except ctrl/tgt, which are forced to 1.
   function automatic logic [IXW-1:0] insert_ones(input logic [IXW-1:0] cnt,
                                                  input logic [QIW-1:0] ctrl,
                                                  input logic [QIW-1:0] tgt);
      logic [IXW-1:0] idx;
      logic [QIW-1:0] j;
      idx = '0;
      j   = '0;
      for (int p = 0; p < IXW; p++) begin
         if (QIW'(p) == ctrl || QIW'(p) == tgt) begin
            idx[p] = 1'b1;
         end else begin
            idx[p] = cnt[j];
            j      = j + QIW'(1);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/crot_index_gen.sv
// crot_index_gen: scan counter and bank index formation for crot_scheduler.
// Config macro: CROT_FAST_SCAN_EN -- when defined, only qualifying addresses are visited
// (NQ-2 bit counter with 1s inserted at ctrl/tgt); otherwise a linear scan of all addresses.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clr            clear the counter (scan start)
//   en             advance the counter (scanning)
//   ctrl, tgt      latched control/target qubit indices
//   idx            current bank address
//   last           current address is the final one of the scan
//   wr_en          current address must be written with the rotated value
module crot_index_gen
   import crot_pkg::*;
#(
   parameter int unsigned NQ = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           en,
   input  logic [QIW-1:0] ctrl,
   input  logic [QIW-1:0] tgt,
   output logic [NQ-1:0]  idx,
   output logic           last,
   output logic           wr_en
);

`ifdef CROT_FAST_SCAN_EN
   // NQ=2 still needs a one-bit counter; it only ever holds 0.
   localparam int unsigned CW = (NQ > 2) ? NQ - 2 : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((1 << (NQ - 2)) - 1);
`else
   localparam int unsigned CW = NQ;
   localparam logic [CW-1:0] CNT_LAST = '1;
`endif

   logic [CW-1:0]  cnt_q;
   logic [IXW-1:0] cnt_ext;
   logic [IXW-1:0] idx_full;
   logic           unused_idx_hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign cnt_ext = IXW'(cnt_q);

`ifdef CROT_FAST_SCAN_EN
   assign idx_full = insert_ones(cnt_ext, ctrl, tgt);
   assign wr_en    = 1'b1;
`else
   assign idx_full = cnt_ext;
   assign wr_en    = is_qual(idx_full, ctrl, tgt);
`endif

   assign idx           = idx_full[NQ-1:0];
   assign unused_idx_hi = ^idx_full[IXW-1:NQ];
   assign last          = (cnt_q == CNT_LAST);

endmodule

// File: rtl/crot_scheduler.sv
// crot_scheduler: sequential front-end for the external controlled-rotation unit.
// Holds a 2^NQ amplitude bank; on start, presents every amplitude whose control and target
// bits are both 1 to the rotation unit and writes the returned value back.
// Config macro: CROT_FAST_SCAN_EN (handled inside crot_index_gen).
// Ports:
//   clk, rst_n            clock, async active-low reset (bank returns to |0>)
//   start                 request one controlled rotation (ctrl_idx, tgt_idx, theta sampled)
//   ld_valid/addr/r/i     bank load, ignored while busy
//   rd_addr, rd_r/rd_i    registered readout, one-cycle latency
//   rot_in_r/i, rot_theta amplitude and angle presented to the rotation unit
//   rot_out_r/i           combinational result from the rotation unit
//   busy, done, err       scanning / completion pulse / rejected-start pulse
module crot_scheduler
   import crot_pkg::*;
#(
   parameter int unsigned NQ = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [$clog2(NQ)-1:0]  ctrl_idx,
   input  logic [$clog2(NQ)-1:0]  tgt_idx,
   input  logic [TOTAL_WIDTH-1:0] theta,
   input  logic                   ld_valid,
   input  logic [NQ-1:0]          ld_addr,
   input  logic [TOTAL_WIDTH-1:0] ld_r,
   input  logic [TOTAL_WIDTH-1:0] ld_i,
   input  logic [NQ-1:0]          rd_addr,
   output logic [TOTAL_WIDTH-1:0] rd_r,
   output logic [TOTAL_WIDTH-1:0] rd_i,
   output logic [TOTAL_WIDTH-1:0] rot_in_r,
   output logic [TOTAL_WIDTH-1:0] rot_in_i,
   output logic [TOTAL_WIDTH-1:0] rot_theta,
   input  logic [TOTAL_WIDTH-1:0] rot_out_r,
   input  logic [TOTAL_WIDTH-1:0] rot_out_i,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int unsigned IW    = $clog2(NQ);
   localparam int unsigned DEPTH = 1 << NQ;
   // One extra bit so NQ itself is representable when all IW-bit codes are legal.
   localparam logic [IW:0] NQ_LIM = (IW + 1)'(NQ);

   crot_state_e            state_q, state_d;
   logic                   start_legal;
   logic                   accept;
   logic                   err_d, err_q;
   logic [QIW-1:0]         ctrl_q, tgt_q;
   logic [TOTAL_WIDTH-1:0] theta_q;
   amp_t                   bank_q [DEPTH];
   amp_t                   rd_q;
   logic [NQ-1:0]          idx;
   logic                   last;
   logic                   wr_en;

   assign start_legal = (ctrl_idx != tgt_idx) &&
                        ({1'b0, ctrl_idx} < NQ_LIM) &&
                        ({1'b0, tgt_idx} < NQ_LIM);

   // FIN behaves like IDLE towards start so a new rotation can chain off the done cycle.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         StScan: begin
            if (last) state_d = StFin;
         end
         default: begin
            state_d = StIdle;
            if (start) begin
               if (start_legal) begin
                  state_d = StScan;
                  accept  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         err_q   <= 1'b0;
         ctrl_q  <= '0;
         tgt_q   <= '0;
         theta_q <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (accept) begin
            ctrl_q  <= QIW'(ctrl_idx);
            tgt_q   <= QIW'(tgt_idx);
            theta_q <= theta;
         end
      end
   end

   assign busy = (state_q == StScan);
   assign done = (state_q == StFin);
   assign err  = err_q;

   crot_index_gen #(
      .NQ(NQ)
   ) u_index_gen (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (accept),
      .en   (busy),
      .ctrl (ctrl_q),
      .tgt  (tgt_q),
      .idx  (idx),
      .last (last),
      .wr_en(wr_en)
   );

   // Scan writes own the bank while busy; loads only land outside a scan.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int a = 0; a < DEPTH; a++) begin
            bank_q[a] <= (a == 0) ? {AMP_ONE, AMP_ZERO} : {AMP_ZERO, AMP_ZERO};
         end
      end else if (busy) begin
         if (wr_en) bank_q[idx] <= {rot_out_r, rot_out_i};
      end else if (ld_valid) begin
         bank_q[ld_addr] <= {ld_r, ld_i};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q <= '0;
      end else begin
         rd_q <= bank_q[rd_addr];
      end
   end

   assign rd_r      = rd_q.r;
   assign rd_i      = rd_q.i;
   assign rot_in_r  = busy ? bank_q[idx].r : '0;
   assign rot_in_i  = busy ? bank_q[idx].i : '0;
   assign rot_theta = theta_q;

endmodule

// File: tb/tb_crot_scheduler.sv
// tb_crot_scheduler: directed self-checking bench for crot_scheduler.
// Two instances (NQ=2 and NQ=3) share clock and reset; each has a multiply-by-i rotation stub.
module tb_crot_scheduler;
   import crot_pkg::*;

   localparam int TW = TOTAL_WIDTH;
`ifdef CROT_FAST_SCAN_EN
   localparam int SCAN2 = 1;
   localparam int SCAN3 = 2;
`else
   localparam int SCAN2 = 4;
   localparam int SCAN3 = 8;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // NQ=2 instance
   logic          start2, ld_valid2, busy2, done2, err2;
   logic [0:0]    ctrl2, tgt2;
   logic [1:0]    ld_addr2, rd_addr2;
   logic [TW-1:0] theta2, ld_r2, ld_i2, rd_r2, rd_i2;
   logic [TW-1:0] rot_in_r2, rot_in_i2, rot_theta2, rot_out_r2, rot_out_i2;

   // NQ=3 instance
   logic          start3, ld_valid3, busy3, done3, err3;
   logic [1:0]    ctrl3, tgt3;
   logic [2:0]    ld_addr3, rd_addr3;
   logic [TW-1:0] theta3, ld_r3, ld_i3, rd_r3, rd_i3;
   logic [TW-1:0] rot_in_r3, rot_in_i3, rot_theta3, rot_out_r3, rot_out_i3;

   // Rotation stub: multiply by i.
   assign rot_out_r2 = -rot_in_i2;
   assign rot_out_i2 = rot_in_r2;
   assign rot_out_r3 = -rot_in_i3;
   assign rot_out_i3 = rot_in_r3;

   crot_scheduler #(.NQ(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .ctrl_idx(ctrl2), .tgt_idx(tgt2),
      .theta(theta2), .ld_valid(ld_valid2), .ld_addr(ld_addr2), .ld_r(ld_r2), .ld_i(ld_i2),
      .rd_addr(rd_addr2), .rd_r(rd_r2), .rd_i(rd_i2), .rot_in_r(rot_in_r2),
      .rot_in_i(rot_in_i2), .rot_theta(rot_theta2), .rot_out_r(rot_out_r2),
      .rot_out_i(rot_out_i2), .busy(busy2), .done(done2), .err(err2)
   );

   crot_scheduler #(.NQ(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .ctrl_idx(ctrl3), .tgt_idx(tgt3),
      .theta(theta3), .ld_valid(ld_valid3), .ld_addr(ld_addr3), .ld_r(ld_r3), .ld_i(ld_i3),
      .rd_addr(rd_addr3), .rd_r(rd_r3), .rd_i(rd_i3), .rot_in_r(rot_in_r3),
      .rot_in_i(rot_in_i3), .rot_theta(rot_theta3), .rot_out_r(rot_out_r3),
      .rot_out_i(rot_out_i3), .busy(busy3), .done(done3), .err(err3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read2(input logic [1:0] a, output logic [TW-1:0] r, output logic [TW-1:0] i);
      rd_addr2 = a;
      tick();
      r = rd_r2;
      i = rd_i2;
   endtask

   task automatic read3(input logic [2:0] a, output logic [TW-1:0] r, output logic [TW-1:0] i);
      rd_addr3 = a;
      tick();
      r = rd_r3;
      i = rd_i3;
   endtask

   task automatic load2(input logic [1:0] a, input logic [TW-1:0] r, input logic [TW-1:0] i);
      ld_valid2 = 1'b1; ld_addr2 = a; ld_r2 = r; ld_i2 = i;
      tick();
      ld_valid2 = 1'b0;
   endtask

   task automatic load3(input logic [2:0] a, input logic [TW-1:0] r, input logic [TW-1:0] i);
      ld_valid3 = 1'b1; ld_addr3 = a; ld_r3 = r; ld_i3 = i;
      tick();
      ld_valid3 = 1'b0;
   endtask

   // Returns ticks until done is seen, or -1 when the bound expires.
   task automatic wait_done2(output int n);
      n = -1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (done2) begin
            n = c;
            break;
         end
      end
   endtask

   task automatic wait_done3(output int n);
      n = -1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (done3) begin
            n = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [TW-1:0] r, i, er;
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({busy2, done2, err2, busy3, done3, err3} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b required 000000",
                  {busy2, done2, err2, busy3, done3, err3});
      end
      checks++;
      if ({rot_in_r3, rot_in_i3, rot_theta3} !== '0) begin
         errors++;
         $display("FAIL reset_rot_outputs: got %h required 0", {rot_in_r3, rot_in_i3, rot_theta3});
      end
      rst_n = 1'b1;
      tick();
      for (int a = 0; a < 8; a++) begin
         read3(3'(a), r, i);
         er = (a == 0) ? 8'h10 : 8'h00;
         checks++;
         if (r !== er || i !== 8'h00) begin
            errors++;
            $display("FAIL reset_bank3[%0d]: got (%h,%h) required (%h,00)", a, r, i, er);
         end
      end
      for (int a = 0; a < 4; a++) begin
         read2(2'(a), r, i);
         er = (a == 0) ? 8'h10 : 8'h00;
         checks++;
         if (r !== er || i !== 8'h00) begin
            errors++;
            $display("FAIL reset_bank2[%0d]: got (%h,%h) required (%h,00)", a, r, i, er);
         end
      end
   endtask

   task automatic test_rotate_nq2();
      logic [TW-1:0] r, i;
      int n;
      for (int a = 0; a < 4; a++) load2(2'(a), 8'h10, 8'h00);
      start2 = 1'b1; ctrl2 = 1'b0; tgt2 = 1'b1; theta2 = 8'h25;
      tick();
      start2 = 1'b0;
      checks++;
      if (busy2 !== 1'b1 || rot_theta2 !== 8'h25) begin
         errors++;
         $display("FAIL rot2_start: busy=%b theta=%h required busy=1 theta=25", busy2, rot_theta2);
      end
      checks++;
      if (rot_in_r2 !== 8'h10 || rot_in_i2 !== 8'h00) begin
         errors++;
         $display("FAIL rot2_rot_in: got (%h,%h) required (10,00)", rot_in_r2, rot_in_i2);
      end
      wait_done2(n);
      checks++;
      if (n != SCAN2 || busy2 !== 1'b0) begin
         errors++;
         $display("FAIL rot2_latency: got %0d cycles busy=%b required %0d busy=0", n, busy2, SCAN2);
      end
      tick();
      checks++;
      if (done2 !== 1'b0) begin
         errors++;
         $display("FAIL rot2_done_pulse: done=%b required 0", done2);
      end
      for (int a = 0; a < 4; a++) begin
         read2(2'(a), r, i);
         checks++;
         if (a == 3) begin
            if (r !== 8'h00 || i !== 8'h10) begin
               errors++;
               $display("FAIL rot2_slot3: got (%h,%h) required (00,10)", r, i);
            end
         end else if (r !== 8'h10 || i !== 8'h00) begin
            errors++;
            $display("FAIL rot2_slot%0d: got (%h,%h) required (10,00)", a, r, i);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [TW-1:0] r, i;
      int n;
      load2(2'd3, 8'h10, 8'h00);
      start2 = 1'b1; ctrl2 = 1'b0; tgt2 = 1'b1; theta2 = 8'h01;
      tick();
      start2 = 1'b0;
      wait_done2(n);
      start2 = 1'b1; ctrl2 = 1'b1; tgt2 = 1'b0; theta2 = 8'h02;
      tick();
      start2 = 1'b0;
      checks++;
      if (busy2 !== 1'b1 || err2 !== 1'b0 || rot_theta2 !== 8'h02) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b err=%b theta=%h required 1 0 02",
                  busy2, err2, rot_theta2);
      end
      wait_done2(n);
      checks++;
      if (n != SCAN2) begin
         errors++;
         $display("FAIL b2b_latency: got %0d required %0d", n, SCAN2);
      end
      read2(2'd3, r, i);
      checks++;
      if (r !== 8'hF0 || i !== 8'h00) begin
         errors++;
         $display("FAIL b2b_slot3: got (%h,%h) required (f0,00)", r, i);
      end
      read2(2'd0, r, i);
      checks++;
      if (r !== 8'h10 || i !== 8'h00) begin
         errors++;
         $display("FAIL b2b_slot0: got (%h,%h) required (10,00)", r, i);
      end
   endtask

   task automatic test_illegal_start();
      logic [TW-1:0] r, i;
      start3 = 1'b1; ctrl3 = 2'd1; tgt3 = 2'd1; theta3 = 8'h33;
      tick();
      start3 = 1'b0;
      checks++;
      if (err3 !== 1'b1 || busy3 !== 1'b0) begin
         errors++;
         $display("FAIL illegal_same: err=%b busy=%b required err=1 busy=0", err3, busy3);
      end
      tick();
      checks++;
      if (err3 !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0) begin
         errors++;
         $display("FAIL illegal_pulse: err=%b busy=%b done=%b required 0 0 0", err3, busy3, done3);
      end
      start3 = 1'b1; ctrl3 = 2'd3; tgt3 = 2'd0;
      tick();
      start3 = 1'b0;
      checks++;
      if (err3 !== 1'b1 || busy3 !== 1'b0) begin
         errors++;
         $display("FAIL illegal_range: err=%b busy=%b required err=1 busy=0", err3, busy3);
      end
      read3(3'd0, r, i);
      checks++;
      if (r !== 8'h10 || i !== 8'h00 || rot_theta3 !== 8'h00) begin
         errors++;
         $display("FAIL illegal_bank: got (%h,%h) theta=%h required (10,00) theta=00",
                  r, i, rot_theta3);
      end
   endtask

   task automatic test_lockout();
      logic [TW-1:0] r, i;
      int n;
      load3(3'd6, 8'h02, 8'h00);
      load3(3'd7, 8'h05, 8'h03);
      start3 = 1'b1; ctrl3 = 2'd1; tgt3 = 2'd2; theta3 = 8'h11;
      tick();
      start3 = 1'b0;
      // Mid-scan load and restart attempt.
      ld_valid3 = 1'b1; ld_addr3 = 3'd0; ld_r3 = 8'h7F; ld_i3 = 8'h7F;
      start3 = 1'b1; ctrl3 = 2'd0; tgt3 = 2'd1; theta3 = 8'h44;
      tick();
      ld_valid3 = 1'b0;
      start3 = 1'b0;
      checks++;
      if (err3 !== 1'b0) begin
         errors++;
         $display("FAIL lock_err: err=%b required 0", err3);
      end
      if (!done3) wait_done3(n);
      else n = 0;
      checks++;
      if (n < 0 || rot_theta3 !== 8'h11) begin
         errors++;
         $display("FAIL lock_done: wait=%0d theta=%h required done and theta=11", n, rot_theta3);
      end
      tick();
      checks++;
      if (busy3 !== 1'b0) begin
         errors++;
         $display("FAIL lock_restart: busy=%b required 0", busy3);
      end
      read3(3'd0, r, i);
      checks++;
      if (r !== 8'h10 || i !== 8'h00) begin
         errors++;
         $display("FAIL lock_slot0: got (%h,%h) required (10,00)", r, i);
      end
      read3(3'd6, r, i);
      checks++;
      if (r !== 8'h00 || i !== 8'h02) begin
         errors++;
         $display("FAIL lock_slot6: got (%h,%h) required (00,02)", r, i);
      end
      read3(3'd7, r, i);
      checks++;
      if (r !== 8'hFD || i !== 8'h05) begin
         errors++;
         $display("FAIL lock_slot7: got (%h,%h) required (fd,05)", r, i);
      end
   endtask

   task automatic test_reset_mid_scan();
      logic [TW-1:0] r, i, er;
      logic saw_done;
      load3(3'd5, 8'h08, 8'h04);
      start3 = 1'b1; ctrl3 = 2'd0; tgt3 = 2'd2; theta3 = 8'h55;
      tick();
      start3 = 1'b0;
      checks++;
      if (busy3 !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_busy: busy=%b required 1", busy3);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy3 !== 1'b0 || rot_theta3 !== 8'h00 || rot_in_r3 !== 8'h00) begin
         errors++;
         $display("FAIL rstmid_async: busy=%b theta=%h rot_in_r=%h required 0 00 00",
                  busy3, rot_theta3, rot_in_r3);
      end
      tick();
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done3 || busy3) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_idle: done/busy seen=%b required 0", saw_done);
      end
      for (int a = 0; a < 8; a++) begin
         read3(3'(a), r, i);
         er = (a == 0) ? 8'h10 : 8'h00;
         checks++;
         if (r !== er || i !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_bank[%0d]: got (%h,%h) required (%h,00)", a, r, i, er);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start2 = 1'b0; ctrl2 = '0; tgt2 = '0; theta2 = '0;
      ld_valid2 = 1'b0; ld_addr2 = '0; ld_r2 = '0; ld_i2 = '0; rd_addr2 = '0;
      start3 = 1'b0; ctrl3 = '0; tgt3 = '0; theta3 = '0;
      ld_valid3 = 1'b0; ld_addr3 = '0; ld_r3 = '0; ld_i3 = '0; rd_addr3 = '0;
      test_reset();
      test_rotate_nq2();
      test_back_to_back();
      test_illegal_start();
      test_lockout();
      test_reset_mid_scan();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
